msk_rnd_prng: RTL
=================

# msk_rnd_prng

Masking-randomness source for the MSK gadget library: produces the fresh random bits that HPC2 AND gadgets consume on their `rnd` port. It holds a bank of 64-bit LFSR lanes, is seeded over a 32-bit valid/ready stream, and runs a warm-up phase before presenting output. It then delivers `W` new bits per accepted cycle on a valid/ready interface. It sits at the top of a masked datapath and feeds the concatenated `rnd` buses of all gadgets.

## Interface
- `d`, 2 (`DEFAULTSHARES`): number of shares per sharing.
- `N_AND`, 1: number of HPC2 gadgets fed.
- `WARM`, 16: warm-up cycles, ≥1.
- Derived `W` = `N_AND*d*(d-1)/2`: output width.
- Derived `K` = ceil(`W`/32): number of LFSR lanes.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `seed_in` input 32: seed word.
- `seed_valid` input 1: `seed_in` is valid this cycle.
- `seed_ready` output 1: block accepts a seed word this cycle.
- `reseed` input 1: pulse; abandons output and returns to seeding.
- `rnd` output W: random bits.
- `rnd_valid` output 1: `rnd` is usable.
- `rnd_ready` input 1: consumer takes `rnd` this cycle.
- `busy_warm` output 1: high during warm-up.

## Operation
- **FSM states:** SEED → WARMUP → RUN.
- **Reset (`rst`=1 at an edge):**
  - state=SEED, all lanes 0, seed counter 0, warm counter 0;
  - registered outputs: `rnd`=0, `rnd_valid`=0, `busy_warm`=0;
  - `seed_ready`=1, since it decodes state==SEED.
- **SEED:**
  - Each cycle with `seed_valid`&&`seed_ready`, word n is written into lane n/2: bits [31:0] if n is even, [63:32] if n is odd.
  - The counter spans 0..2K-1.
  - After word 2K-1 is accepted, the next state is WARMUP.
  - On that transition, any lane equal to 64'h0 is forced to 64'h1 (zero-lock guard).
- **Lane step (one "advance"):**
  - Each lane applies 32 unrolled Fibonacci steps.
  - One step: `s <= {s[62:0], s[63]^s[62]^s[60]^s[59]}` (x^64+x^63+x^61+x^60+1).
  - All lanes advance together.
- **WARMUP:**
  - Lanes advance every cycle; `busy_warm`=1, `rnd_valid`=0.
  - After exactly `WARM` advances, the state becomes RUN.
- **RUN:**
  - `rnd_valid`=1.
  - `rnd` = concatenation of each lane's s[31:0], with lane 0 in the LSBs, truncated to W.
  - Lanes advance only on cycles where `rnd_valid`&&`rnd_ready`. The next value appears the following cycle.
  - With `rnd_ready` held at 1, a new value appears every cycle with no bubbles.
- **`reseed`=1 in any state:**
  - Next state is SEED and the seed counter is cleared.
  - Lanes keep their values until they are overwritten.
  - `rnd_valid` and `busy_warm` are 0 from the next cycle.
- **Priority:** `rst` > `reseed` > seed write / advance.
  - `reseed` together with an accepted seed word: the word is discarded and the counter is 0 afterward.
  - `reseed` together with a RUN handshake: the handshake completes (that value is consumed), but no further valid is issued.
- **Output stability:** `rnd` is registered (lane state). It never changes while `rnd_valid`=1 and `rnd_ready`=0.
- **No wrap of the seed counter:** SEED always exits after exactly 2K words. Extra `seed_valid` outside SEED is ignored because `seed_ready`=0.

## Timing
- **Seeding:** 2K accepted handshakes; zero-wait when `seed_valid` is held at 1.
- **Seed to output:** last seed word accepted at edge t → WARMUP from t. The first `rnd_valid`=1 is visible after edge t+`WARM`.
- **RUN throughput:** one W-bit value per cycle. The value advances at the edge where the handshake occurs.
- **Outputs:** `seed_ready` is combinational from state only, with no path from inputs. All other outputs are registered.
- **Gadget compatibility:** gadgets expect `rnd` fresh every cycle. A consumer therefore holds `rnd_ready`=1 whenever its pipeline is active.

## Test plan
- **Reset values:** `rst` for 2 cycles → `seed_ready`=1, `rnd_valid`=0, `busy_warm`=0, `rnd`=0. Repeat with `rst` asserted mid-RUN; the same values follow the next edge.
- **Basic flow:** d=2, N_AND=1 (W=1, K=1), seed words 0xDEADBEEF, 0x01234567 back-to-back.
  - Lane = 64'h01234567DEADBEEF.
  - `busy_warm`=1 for 16 cycles, then `rnd_valid`=1.
  - 100 consecutive `rnd` values match the bit-exact software model of the lane step.
- **Zero seed:** both words 0 → lane forced to 64'h1; the output sequence equals the model started from 1; the lane is never all-zero.
- **Multi-lane with back-pressure:** d=3, N_AND=12 (W=36, K=2), 4 seed words.
  - Toggle `rnd_ready` randomly; `rnd` holds while ready=0.
  - Accepted values equal the model sequence with no skips or duplicates.
  - `rnd[35:32]` comes from lane 1 bits [3:0].
- **Reseed:**
  - `reseed` during RUN → `rnd_valid`=0 the next cycle, `seed_ready`=1; reseeding with new words yields the new model sequence.
  - `reseed` in the same cycle as seed word 1 → the counter restarts and 2K fresh words are required.
- **Stall during seeding:** insert random `seed_valid` gaps → lane contents are identical to the back-to-back case; words sent while `seed_ready`=0 have no effect.

Source files
------------

// File: rtl/msk_rnd_prng.sv
// Masking-randomness source: a bank of 64-bit LFSR lanes, seeded over a 32-bit
// valid/ready stream, warmed up, then delivering W fresh bits per accepted cycle.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_SEED   | accepting 2K seed words into the lanes, seed_ready=1
// ST_WARMUP | lanes advance every cycle for WARM cycles, busy_warm=1
// ST_RUN    | rnd_valid=1, lanes advance on each rnd handshake
module msk_rnd_prng #(
  parameter int d     = 2,
  parameter int N_AND = 1,
  parameter int WARM  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   seed_in,
  input  logic                          seed_valid,
  output logic                          seed_ready,
  input  logic                          reseed,
  output logic [N_AND*d*(d-1)/2-1:0]    rnd,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic                          busy_warm
);

  localparam int W  = N_AND * d * (d - 1) / 2;
  localparam int K  = (W + 31) / 32;
  localparam int CW = (2 * K > 1) ? $clog2(2 * K) : 1;
  localparam int WW = $clog2(WARM + 1);
  localparam logic [CW-1:0] SEED_LAST = CW'(2 * K - 1);

  typedef enum logic [1:0] {ST_SEED, ST_WARMUP, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   seed_cnt_q, seed_cnt_d;
  logic [WW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [63:0]     lane_q [K];
  logic [63:0]     lane_d [K];
  logic            rnd_valid_q, busy_warm_q;
  logic            advance;

  // 32 unrolled Fibonacci steps of x^64+x^63+x^61+x^60+1
  function automatic logic [63:0] step32(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < 32; i++) begin
      t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    end
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      seed_cnt_q  <= '0;
      warm_cnt_q  <= '0;
      rnd_valid_q <= 1'b0;
      busy_warm_q <= 1'b0;
      for (int i = 0; i < K; i++) lane_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      rnd_valid_q <= (state_d == ST_RUN);
      busy_warm_q <= (state_d == ST_WARMUP);
      for (int i = 0; i < K; i++) lane_q[i] <= lane_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    warm_cnt_d = warm_cnt_q;
    advance    = 1'b0;
    for (int i = 0; i < K; i++) lane_d[i] = lane_q[i];

    case (state_q)
      ST_SEED: begin
        if (seed_valid) begin
          for (int i = 0; i < K; i++) begin
            if ((seed_cnt_q >> 1) == CW'(i)) begin
              if (seed_cnt_q[0]) lane_d[i][63:32] = seed_in;
              else               lane_d[i][31:0]  = seed_in;
            end
          end
          if (seed_cnt_q == SEED_LAST) begin
            state_d    = ST_WARMUP;
            seed_cnt_d = '0;
            warm_cnt_d = WW'(WARM - 1);
            // an all-zero lane would lock up forever
            for (int i = 0; i < K; i++) begin
              if (lane_d[i] == 64'h0) lane_d[i] = 64'h1;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
      end
      ST_WARMUP: begin
        advance = 1'b1;
        if (warm_cnt_q == '0) state_d = ST_RUN;
        else                  warm_cnt_d = warm_cnt_q - 1'b1;
      end
      ST_RUN: begin
        advance = rnd_valid_q && rnd_ready;
      end
      default: state_d = ST_SEED;
    endcase

    // a RUN handshake coinciding with reseed still consumes its value
    if (reseed) begin
      state_d    = ST_SEED;
      seed_cnt_d = '0;
      if (state_q != ST_RUN) begin
        advance = 1'b0;
        for (int i = 0; i < K; i++) lane_d[i] = lane_q[i];
      end
    end

    if (advance) begin
      for (int i = 0; i < K; i++) lane_d[i] = step32(lane_q[i]);
    end
  end

  always_comb begin
    rnd = '0;
    for (int b = 0; b < W; b++) rnd[b] = lane_q[b / 32][b % 32];
  end

  assign seed_ready = (state_q == ST_SEED);
  assign rnd_valid  = rnd_valid_q;
  assign busy_warm  = busy_warm_q;

endmodule
